// File: rtl/dmac_pkg.sv
// Shared DMA command encodings and sequencer state type, used by the core's
// control unit and by dmac_seq.
package dmac_pkg;

  localparam logic [1:0] DMA_NOP = 2'b00;
  localparam logic [1:0] DMA_D2S = 2'b01;
  localparam logic [1:0] DMA_S2D = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D2S  = 2'd1,
    S2D  = 2'd2
  } dmac_state_e;

  // 2'b11 is reserved and behaves like a nop.
  function automatic logic is_xfer_cmd(input logic [1:0] cmd);
    return (cmd == DMA_D2S) || (cmd == DMA_S2D);
  endfunction

endpackage

// File: rtl/dmac_seq.sv
// DMA sequencer: moves word blocks between DRAM and SRAM and freezes the core
// via stall while busy. Optional per-word DRAM timeout behind DMAC_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a d2s/s2d command with non-zero width
// D2S   | reading DRAM word idx, writing it to SRAM on dramValid
// S2D   | writing SRAM word idx to DRAM, advancing on dramValid
module dmac_seq
  import dmac_pkg::*;
#(
  parameter int SRAM_AW        = 14,
  parameter int WIDTH_W        = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         dmaCmd,
  input  logic [31:0]        dmaSrcAddress,
  input  logic [31:0]        dmaDstAddress,
  input  logic [WIDTH_W-1:0] dmaWidth,
  input  logic [31:0]        sramReadData,
  input  logic [31:0]        dramReadData,
  output logic [SRAM_AW-1:0] sramAddress,
  output logic [31:0]        sramWriteData,
  output logic               sramWriteEnable,
  output logic [31:0]        dramAddress,
  output logic [31:0]        dramWriteData,
  output logic               dramWriteEnable,
  output logic               dramReadEnable,
  input  logic               dramValid,
  output logic               stall
`ifdef DMAC_TIMEOUT_EN
  ,
  output logic               dmaErr
`endif
);

  if (TIMEOUT_CYCLES < 2 || WIDTH_W < 1 || SRAM_AW < 1 || SRAM_AW > 30) begin : g_bad_param
    $error("dmac_seq: unsupported parameter set");
  end

  dmac_state_e        state;
  logic [31:0]        src;
  logic [31:0]        dst;
  logic [WIDTH_W-1:0] width;
  logic [WIDTH_W-1:0] idx;
  logic               last_word;
  logic               abort;
  logic [SRAM_AW-1:0] sram_base;
  logic [SRAM_AW-1:0] sram_word;
  logic [31:0]        dram_base;
  logic [31:0]        dram_byte;

  assign last_word = (idx == width - WIDTH_W'(1));

  // One adder per memory; the direction only selects which latched address feeds it.
  assign sram_base = (state == D2S) ? dst[SRAM_AW+1:2] : src[SRAM_AW+1:2];
  assign sram_word = sram_base + SRAM_AW'(idx);
  assign dram_base = (state == D2S) ? src : dst;
  assign dram_byte = dram_base + (32'(idx) << 2);

`ifdef DMAC_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt;

  assign abort = (state != IDLE) && !dramValid && (wait_cnt == '0);

  // Reloaded while idle and on every completed word, so each word gets the full budget.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      dmaErr   <= 1'b0;
    end else begin
      if (state == IDLE || dramValid || abort) begin
        wait_cnt <= TO_LOAD;
      end else begin
        wait_cnt <= wait_cnt - TO_W'(1);
      end
      if (abort) begin
        dmaErr <= 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    sramAddress     = '0;
    sramWriteData   = '0;
    sramWriteEnable = 1'b0;
    dramAddress     = '0;
    dramWriteData   = '0;
    dramWriteEnable = 1'b0;
    dramReadEnable  = 1'b0;
    unique case (state)
      D2S: begin
        dramAddress    = dram_byte;
        dramReadEnable = 1'b1;
        if (dramValid) begin
          sramWriteEnable = 1'b1;
          sramAddress     = sram_word;
          sramWriteData   = dramReadData;
        end
      end
      S2D: begin
        sramAddress     = sram_word;
        dramAddress     = dram_byte;
        dramWriteData   = sramReadData;
        dramWriteEnable = 1'b1;
      end
      default: ;
    endcase
  end

  // stall tracks the next state so it is low in the command cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      width <= '0;
      idx   <= '0;
      stall <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_xfer_cmd(dmaCmd) && dmaWidth != '0) begin
            src   <= dmaSrcAddress;
            dst   <= dmaDstAddress;
            width <= dmaWidth;
            idx   <= '0;
            stall <= 1'b1;
            state <= (dmaCmd == DMA_D2S) ? D2S : S2D;
          end
        end
        D2S, S2D: begin
          if (dramValid) begin
            idx <= idx + WIDTH_W'(1);
            if (last_word) begin
              state <= IDLE;
              stall <= 1'b0;
            end
          end else if (abort) begin
            state <= IDLE;
            stall <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_seq.sv
// Randomized bench for dmac_seq with DRAM/SRAM behavioural models and a
// block-level reference of what each command must do to memory and stall.
module tb_dmac_seq;
  import dmac_pkg::*;

  localparam int SRAM_AW    = 14;
  localparam int WIDTH_W    = 10;
  localparam int SRAM_WORDS = 1 << SRAM_AW;
`ifdef DMAC_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1024;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         dmaCmd = 2'b00;
  logic [31:0]        dmaSrcAddress = '0;
  logic [31:0]        dmaDstAddress = '0;
  logic [WIDTH_W-1:0] dmaWidth = '0;
  logic [31:0]        sramReadData;
  logic [31:0]        dramReadData;
  logic [SRAM_AW-1:0] sramAddress;
  logic [31:0]        sramWriteData;
  logic               sramWriteEnable;
  logic [31:0]        dramAddress;
  logic [31:0]        dramWriteData;
  logic               dramWriteEnable;
  logic               dramReadEnable;
  logic               dramValid = 1'b0;
  logic               stall;
`ifdef DMAC_TIMEOUT_EN
  logic               dmaErr;
`endif

  dmac_seq #(.SRAM_AW(SRAM_AW), .WIDTH_W(WIDTH_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .dmaCmd(dmaCmd),
    .dmaSrcAddress(dmaSrcAddress), .dmaDstAddress(dmaDstAddress), .dmaWidth(dmaWidth),
    .sramReadData(sramReadData), .dramReadData(dramReadData),
    .sramAddress(sramAddress), .sramWriteData(sramWriteData), .sramWriteEnable(sramWriteEnable),
    .dramAddress(dramAddress), .dramWriteData(dramWriteData),
    .dramWriteEnable(dramWriteEnable), .dramReadEnable(dramReadEnable),
    .dramValid(dramValid), .stall(stall)
`ifdef DMAC_TIMEOUT_EN
    , .dmaErr(dmaErr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dram_fn(input logic [31:0] a);
    return (a * 32'h0001_0001) ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [31:0] sram_init(input int unsigned a);
    return 32'hA500_0000 ^ (a * 32'h0000_9E37);
  endfunction

  // Physical SRAM as written by the DUT; unwritten words read as their initial pattern.
  logic [31:0] sram_mem     [SRAM_WORDS];
  bit          sram_written [SRAM_WORDS];
  // Reference SRAM contents maintained purely from command semantics.
  logic [31:0] sram_exp     [SRAM_WORDS];

  function automatic logic [31:0] sram_rd(input logic [SRAM_AW-1:0] a);
    return sram_written[a] ? sram_mem[a] : sram_init(int'(a));
  endfunction

  assign sramReadData = sram_rd(sramAddress);
  assign dramReadData = dram_fn(dramAddress);

  int  fixed_lat  = 0;
  bit  idle_noise = 1'b0;
  bit  hold_low   = 1'b0;
  int  cur_lat    = 0;
  int  wcnt       = 0;
  int  word_cycles = 0;
  int  stall_cnt  = 0;
  int  sram_wr_cnt = 0;
  logic [63:0] dram_wr_q [$];

  function automatic int next_lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk) begin
    if (sramWriteEnable) begin
      sram_mem[sramAddress]     <= sramWriteData;
      sram_written[sramAddress] <= 1'b1;
      sram_wr_cnt <= sram_wr_cnt + 1;
    end
    if (dramWriteEnable && dramValid) dram_wr_q.push_back({dramAddress, dramWriteData});
    if (stall) stall_cnt <= stall_cnt + 1;
    if (!reset && (dramReadEnable || dramWriteEnable)) begin
      if (dramValid) begin
        wcnt        <= 0;
        cur_lat     <= next_lat();
        word_cycles <= word_cycles + cur_lat + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt    <= 0;
      cur_lat <= next_lat();
    end
  end

  always @(negedge clk) begin
    if (reset) dramValid <= 1'b0;
    else if (dramReadEnable || dramWriteEnable) dramValid <= !hold_low && (wcnt == cur_lat);
    else dramValid <= idle_noise && ($urandom_range(0, 1) == 1);
  end

  task automatic run_cmd(input logic [1:0] cmd, input logic [31:0] s, input logic [31:0] d,
                         input int w, input int lat, input bit junk, output int stall_cycles);
    int s0, c0, w0, q0;
    bit done, active;
    logic [SRAM_AW-1:0] a;
    logic [63:0] got, e;
    active = (cmd == DMA_D2S || cmd == DMA_S2D) && (w != 0);
    fixed_lat = lat;
    @(negedge clk);
    s0 = stall_cnt; c0 = word_cycles; w0 = sram_wr_cnt; q0 = dram_wr_q.size();
    dmaCmd = cmd; dmaSrcAddress = s; dmaDstAddress = d; dmaWidth = WIDTH_W'(w);
    check("stall_cmd_cycle", 64'(stall), 64'(0));
    @(negedge clk);
    check("stall_after_cmd", 64'(stall), 64'(active));
    dmaCmd = DMA_NOP;
    done = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if (!stall) begin done = 1'b1; break; end
      if (junk) begin
        dmaCmd = 2'($urandom_range(0, 3));
        dmaWidth = WIDTH_W'($urandom);
        dmaSrcAddress = $urandom;
        dmaDstAddress = $urandom;
      end
      @(negedge clk);
    end
    dmaCmd = DMA_NOP;
    check("xfer_done", 64'(done), 64'(1));
    repeat (2) @(negedge clk);
    stall_cycles = stall_cnt - s0;
    check("stall_cycles", 64'(stall_cycles), 64'(word_cycles - c0));
    check("idle_strobes", {61'(0), sramWriteEnable, dramReadEnable, dramWriteEnable}, 64'(0));
    if (active && cmd == DMA_D2S) begin
      check("sram_wr_count", 64'(sram_wr_cnt - w0), 64'(w));
      for (int i = 0; i < w; i++) begin
        a = SRAM_AW'((d >> 2) + 32'(i));
        sram_exp[a] = dram_fn(s + 32'(4 * i));
      end
      for (int i = 0; i < w; i++) begin
        a = SRAM_AW'((d >> 2) + 32'(i));
        check($sformatf("sram_word[%0d]", i), 64'(sram_rd(a)), 64'(sram_exp[a]));
      end
    end else begin
      check("no_sram_writes", 64'(sram_wr_cnt - w0), 64'(0));
    end
    if (active && cmd == DMA_S2D) begin
      check("dram_wr_count", 64'(dram_wr_q.size() - q0), 64'(w));
      for (int i = 0; i < w; i++) begin
        a = SRAM_AW'((s >> 2) + 32'(i));
        e = {d + 32'(4 * i), sram_exp[a]};
        got = (q0 + i < dram_wr_q.size()) ? dram_wr_q[q0 + i] : '1;
        check($sformatf("dram_write[%0d]", i), got, e);
      end
    end else begin
      check("no_dram_writes", 64'(dram_wr_q.size() - q0), 64'(0));
    end
  endtask

  initial begin
    int sc, w0, wr_n;
    bit hit;
    logic [1:0] cmd;
    for (int i = 0; i < SRAM_WORDS; i++) sram_exp[i] = sram_init(i);

    repeat (3) @(negedge clk);
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_outputs", {sramAddress, sramWriteEnable, dramReadEnable, dramWriteEnable, dramAddress[16:0]}, 64'(0));
    check("reset_data", {sramWriteData, dramWriteData}, 64'(0));
`ifdef DMAC_TIMEOUT_EN
    check("reset_err", 64'(dmaErr), 64'(0));
`endif
    reset = 1'b0;
    idle_noise = 1'b1;

    // d2s 0x1000 -> word 0x10, four words, two wait cycles each
    run_cmd(DMA_D2S, 32'h1000, 32'h40, 4, 2, 1'b0, sc);
    check("tp1_stall_len", 64'(sc), 64'(12));
    check("tp1_first", 64'(sram_rd(14'h10)), 64'(dram_fn(32'h1000)));
    check("tp1_last", 64'(sram_rd(14'h13)), 64'(dram_fn(32'h100C)));

    // s2d word 0 -> 0x2000, zero-wait
    run_cmd(DMA_S2D, 32'h0, 32'h2000, 3, 0, 1'b0, sc);
    check("tp2_stall_len", 64'(sc), 64'(3));
    check("tp2_last_addr", 64'(dram_wr_q[dram_wr_q.size() - 1][63:32]), 64'(32'h2008));

    run_cmd(DMA_D2S, 32'h1234, 32'h88, 0, 0, 1'b0, sc);
    check("w0_no_stall", 64'(sc), 64'(0));

    // reset after 2 of 5 words
    fixed_lat = 2;
    @(negedge clk);
    w0 = sram_wr_cnt;
    dmaCmd = DMA_D2S; dmaSrcAddress = 32'h3000; dmaDstAddress = 32'h800; dmaWidth = 10'd5;
    @(negedge clk);
    dmaCmd = DMA_NOP;
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (sram_wr_cnt - w0 == 2) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_two_words_seen", 64'(hit), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_outputs", {sramAddress, sramWriteEnable, dramReadEnable, dramWriteEnable, dramAddress[16:0]}, 64'(0));
    check("rst_data", {sramWriteData, dramWriteData}, 64'(0));
    reset = 1'b0;
    wr_n = sram_wr_cnt - w0;
    check("rst_partial_count", 64'(wr_n), 64'(2));
    for (int i = 0; i < 2; i++) sram_exp[14'h200 + i] = dram_fn(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_word[%0d]", i), 64'(sram_rd(SRAM_AW'(14'h200 + i))), 64'(sram_exp[14'h200 + i]));
    run_cmd(DMA_S2D, 32'h800, 32'hA000, 2, 1, 1'b0, sc);

    // SRAM address wrap
    run_cmd(DMA_D2S, 32'h5000, 32'hFFFC, 2, 1, 1'b1, sc);
    check("wrap_word_3fff", 64'(sram_rd(14'h3FFF)), 64'(dram_fn(32'h5000)));
    check("wrap_word_0", 64'(sram_rd(14'h0000)), 64'(dram_fn(32'h5004)));

    for (int t = 0; t < 12; t++) begin
      cmd = 2'($urandom_range(0, 3));
      run_cmd(cmd, $urandom, $urandom, int'($urandom_range(1, 24)), -1, 1'($urandom), sc);
    end

    run_cmd(DMA_D2S, $urandom, $urandom, 1023, 0, 1'b0, sc);
    check("max_width_len", 64'(sc), 64'(1023));

`ifdef DMAC_TIMEOUT_EN
    hold_low = 1'b1;
    fixed_lat = 0;
    @(negedge clk);
    w0 = stall_cnt;
    dmaCmd = DMA_D2S; dmaSrcAddress = 32'h100; dmaDstAddress = 32'h100; dmaWidth = 10'd3;
    @(negedge clk);
    dmaCmd = DMA_NOP;
    repeat (12) @(negedge clk);
    check("to_stall_len", 64'(stall_cnt - w0), 64'(TO_CYC));
    check("to_stall_low", 64'(stall), 64'(0));
    check("to_err", 64'(dmaErr), 64'(1));
    hold_low = 1'b0;
    run_cmd(DMA_S2D, 32'h40, 32'h7000, 2, 1, 1'b0, sc);
    check("to_err_sticky", 64'(dmaErr), 64'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
